mem_io_bridge: RTL

Sits directly downstream of the CPU top's memory bus (mem_a/mem_dout/mem_wr/mem_din/io_buffer_full). Decodes each byte access to either the 128 KB RAM or the memory-mapped I/O window (mem_a[17:16]==2'b11). Buffers UART output bytes in a TX FIFO and drives io_buffer_full back to the CPU. Provides the cycle counter and the program-stop flag.

---
 rtl/mem_io_bridge_pkg.sv | 34 +++
 rtl/mem_io_bridge_tx_fifo.sv | 54 +++++
 rtl/mem_io_bridge.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mem_io_bridge_pkg.sv
// Shared decode constants and read-source select encoding for mem_io_bridge.
package mem_io_bridge_pkg;

   localparam logic [17:0] IO_BASE     = 18'h3_0000;
   localparam logic [15:0] IO_DATA_OFS = 16'h0000;
   localparam logic [15:0] IO_CLK_OFS  = 16'h0004;

   // SEL_ZERO covers unmapped I/O reads and RX reads with nothing pending.
   typedef enum logic [2:0] {
      SEL_RAM  = 3'd0,
      SEL_RX   = 3'd1,
      SEL_ZERO = 3'd2,
      SEL_CNT0 = 3'd4,
      SEL_CNT1 = 3'd5,
      SEL_CNT2 = 3'd6,
      SEL_CNT3 = 3'd7
   } rd_sel_t;

   function automatic logic is_io(input logic [17:0] a);
      return a[17:16] == IO_BASE[17:16];
   endfunction

   function automatic rd_sel_t cnt_sel(input logic [1:0] b);
      rd_sel_t s;
      case (b)
         2'd0:    s = SEL_CNT0;
         2'd1:    s = SEL_CNT1;
         2'd2:    s = SEL_CNT2;
         default: s = SEL_CNT3;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/mem_io_bridge_tx_fifo.sv
// io_tx_fifo: synchronous FIFO with occupancy count; pushes into a full FIFO are
// dropped unless a pop frees a slot in the same cycle.
module io_tx_fifo #(
   parameter int DEPTH_LOG = 3,
   parameter int WIDTH     = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push,
   input  logic [WIDTH-1:0]     push_data,
   input  logic                 pop,
   output logic [WIDTH-1:0]     head,
   output logic [DEPTH_LOG:0]   count,
   output logic                 full,
   output logic                 empty
);

   localparam int DEPTH = 1 << DEPTH_LOG;
   localparam logic [DEPTH_LOG:0] CNT_FULL = (DEPTH_LOG+1)'(DEPTH);
   localparam logic [DEPTH_LOG:0] CNT_ONE  = (DEPTH_LOG+1)'(1);

   logic [WIDTH-1:0]     mem [DEPTH];
   logic [DEPTH_LOG-1:0] wr_ptr;
   logic [DEPTH_LOG-1:0] rd_ptr;
   logic                 do_push;
   logic                 do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_FULL);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG'(1);
         if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/mem_io_bridge.sv
// CPU memory-bus bridge: RAM/I-O decode, UART TX FIFO, cycle counter, stop flag.
// Optional RX read port enabled by defining IO_RX_PORT_EN.
module mem_io_bridge
   import mem_io_bridge_pkg::*;
#(
   parameter int TX_DEPTH_LOG = 3,
   parameter int FULL_MARGIN  = 2,
   parameter int RAM_ADDR_W   = 17
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic [31:0]           cpu_a,
   input  logic [7:0]            cpu_dout,
   input  logic                  cpu_wr,
   output logic [7:0]            cpu_din,
   output logic                  io_buffer_full,
   output logic [RAM_ADDR_W-1:0] ram_a,
   output logic                  ram_we,
   output logic [7:0]            ram_wdata,
   input  logic [7:0]            ram_rdata,
   output logic                  tx_valid,
   output logic [7:0]            tx_data,
   input  logic                  tx_ready,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   output logic                  rx_pop,
   output logic                  prog_stop
);

   localparam int FULL_THR_I = (1 << TX_DEPTH_LOG) - FULL_MARGIN;
   localparam logic [TX_DEPTH_LOG:0] FULL_THR = FULL_THR_I[TX_DEPTH_LOG:0];

   logic                  io;
   logic [15:0]           ofs;
   logic                  acc_rd;
   logic                  acc_wr;
   logic                  hit_data;
   logic                  hit_clk;
   logic                  hit_clk_base;
   logic                  push_data;
   logic                  stop_wr;
   logic                  fifo_push;
   logic [7:0]            fifo_wdata;
   logic                  fifo_pop;
   logic [TX_DEPTH_LOG:0] fifo_count;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  rx_take;
   logic [7:0]            rx_byte;
   rd_sel_t               rd_sel;
   rd_sel_t               sel_next;
   logic                  rd_active;
   logic [31:0]           cycle_cnt;
   logic [31:0]           cnt_snap;
   logic                  unused_hi;

   assign unused_hi    = ^cpu_a[31:18];

   assign io           = is_io(cpu_a[17:0]);
   assign ofs          = cpu_a[15:0];
   assign acc_rd       = rdy_in & ~cpu_wr;
   assign acc_wr       = rdy_in & cpu_wr;
   assign hit_data     = io & (ofs == IO_DATA_OFS);
   assign hit_clk_base = io & (ofs == IO_CLK_OFS);
   assign hit_clk      = io & (ofs[15:2] == IO_CLK_OFS[15:2]);

   assign ram_a        = cpu_a[RAM_ADDR_W-1:0];
   assign ram_we       = acc_wr & ~io;
   assign ram_wdata    = cpu_dout;

   // The stop write always emits one 0x00 so the host sees an end marker.
   assign push_data    = acc_wr & hit_data & (cpu_dout != 8'h00) & ~prog_stop;
   assign stop_wr      = acc_wr & hit_clk_base & ~prog_stop;
   assign fifo_push    = push_data | stop_wr;
   assign fifo_wdata   = stop_wr ? 8'h00 : cpu_dout;
   assign fifo_pop     = tx_valid & tx_ready;
   assign tx_valid     = ~fifo_empty;

   io_tx_fifo #(
      .DEPTH_LOG (TX_DEPTH_LOG),
      .WIDTH     (8)
   ) u_tx_fifo (
      .clk       (clk_in),
      .rst_n     (rst_in),
      .push      (fifo_push),
      .push_data (fifo_wdata),
      .pop       (fifo_pop),
      .head      (tx_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

`ifdef IO_RX_PORT_EN
   assign rx_take = acc_rd & hit_data & rx_valid;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         rx_byte <= 8'h00;
      end else if (rx_take) begin
         rx_byte <= rx_data;
      end
   end
`else
   logic unused_rx;
   assign rx_take   = 1'b0;
   assign rx_byte   = 8'h00;
   assign unused_rx = ^{rx_valid, rx_data};
`endif

   assign rx_pop = rx_take;

   always_comb begin
      sel_next = rd_sel;
      if (acc_rd) begin
         if (!io)           sel_next = SEL_RAM;
         else if (hit_data) sel_next = rx_take ? SEL_RX : SEL_ZERO;
         else if (hit_clk)  sel_next = cnt_sel(cpu_a[1:0]);
         else               sel_next = SEL_ZERO;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         rd_sel         <= SEL_RAM;
         rd_active      <= 1'b0;
         cycle_cnt      <= 32'h0;
         cnt_snap       <= 32'h0;
         prog_stop      <= 1'b0;
         io_buffer_full <= 1'b0;
      end else begin
         rd_sel         <= sel_next;
         rd_active      <= acc_rd;
         io_buffer_full <= (fifo_count >= FULL_THR);
         if (rdy_in)                 cycle_cnt <= cycle_cnt + 32'd1;
         if (acc_rd & hit_clk_base)  cnt_snap  <= cycle_cnt;
         if (stop_wr)                prog_stop <= 1'b1;
      end
   end

   // rd_active keeps cpu_din at 0 out of reset and after non-read cycles.
   always_comb begin
      cpu_din = 8'h00;
      if (rd_active) begin
         case (rd_sel)
            SEL_RAM:  cpu_din = ram_rdata;
            SEL_RX:   cpu_din = rx_byte;
            SEL_CNT0: cpu_din = cnt_snap[7:0];
            SEL_CNT1: cpu_din = cnt_snap[15:8];
            SEL_CNT2: cpu_din = cnt_snap[23:16];
            SEL_CNT3: cpu_din = cnt_snap[31:24];
            default:  cpu_din = 8'h00;
         endcase
      end
   end

   logic unused_full;
   assign unused_full = fifo_full;

endmodule
